pwqe_station_buffer: RTL



---
 rtl/pwqe_station_buffer.sv | 95 +++++++++
 1 files changed

// File: rtl/pwqe_station_buffer.sv
// Slot buffer for bandwidth-sensitive partial WQEs: upstream enqueue into the lowest free
// slot, scheduler read/write-back on port 1, and release of a slot when its transport completes.
module pwqe_station_buffer #(
  parameter int WQE_WIDTH           = 512,
  parameter int PWQE_SLOT_NUM       = 4,
  parameter int PWQE_BUF_ADDR_WIDTH = 2,
  parameter int PWQE_BUF_WIDTH      = 512
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_enq_val,
  output logic                           o_enq_rdy,
  input  logic [WQE_WIDTH-1:0]           i_enq_wqe,
  output logic [PWQE_BUF_ADDR_WIDTH-1:0] o_enq_addr,
  input  logic                           i_ren_1,
  input  logic                           i_wen_1,
  input  logic [PWQE_BUF_ADDR_WIDTH-1:0] i_addr_1,
  input  logic [PWQE_BUF_WIDTH-1:0]      i_din_1,
  output logic [PWQE_BUF_WIDTH-1:0]      o_dout_1,
  output logic [PWQE_SLOT_NUM-1:0]       o_slot_status,
  input  logic                           i_free_val,
  input  logic [PWQE_BUF_ADDR_WIDTH-1:0] i_free_addr,
  output logic                           o_err
);

  logic [PWQE_SLOT_NUM-1:0]       valid_q, valid_d;
  logic [PWQE_BUF_WIDTH-1:0]      dout_q, dout_d;
  logic                           err_q, err_d;
  logic [PWQE_BUF_WIDTH-1:0]      slot_q [PWQE_SLOT_NUM];

  logic [PWQE_BUF_ADDR_WIDTH-1:0] enq_addr;
  logic                           enq_rdy;
  logic                           enq_fire;
  logic                           wr_ok;
  logic                           wr_bad;
  logic                           free_ok;
  logic                           free_bad;
  logic [PWQE_BUF_WIDTH-1:0]      enq_data;

  assign enq_rdy  = |(~valid_q);
  assign enq_fire = i_enq_val & enq_rdy;
  assign enq_data = PWQE_BUF_WIDTH'(i_enq_wqe);

  // Scanning from the top down leaves the lowest free index; 0 when full.
  always_comb begin
    enq_addr = '0;
    for (int k = PWQE_SLOT_NUM - 1; k >= 0; k--) begin
      if (!valid_q[k]) enq_addr = PWQE_BUF_ADDR_WIDTH'(k);
    end
  end

  assign wr_ok    = i_wen_1 &  valid_q[i_addr_1];
  assign wr_bad   = i_wen_1 & ~valid_q[i_addr_1];
  assign free_ok  = i_free_val &  valid_q[i_free_addr];
  assign free_bad = i_free_val & ~valid_q[i_free_addr];

  // Enqueue only targets a free slot and free only clears an occupied one, so they never collide.
  always_comb begin
    valid_d = valid_q;
    if (free_ok)  valid_d[i_free_addr] = 1'b0;
    if (enq_fire) valid_d[enq_addr]    = 1'b1;
  end

  always_comb begin
    dout_d = dout_q;
    if (i_ren_1) dout_d = wr_ok ? i_din_1 : slot_q[i_addr_1];
  end

  assign err_d = err_q | wr_bad | free_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  // Slot payload carries no reset; its contents only matter once a slot has been written.
  always_ff @(posedge clk) begin
    if (enq_fire) slot_q[enq_addr] <= enq_data;
    if (wr_ok)    slot_q[i_addr_1] <= i_din_1;
  end

  assign o_enq_rdy     = enq_rdy;
  assign o_enq_addr    = enq_addr;
  assign o_dout_1      = dout_q;
  assign o_slot_status = valid_q;
  assign o_err         = err_q;

endmodule
